// File: rtl/i2c_config_pkg.sv
// Shared types and defaults for the I2C configuration sequencer and its word table.
package i2c_config_pkg;

  localparam int CFG_WORD_W        = 24;
  localparam int DEF_NUM_REGS      = 10;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_TIMEOUT       = 64;

  typedef enum logic [3:0] {
    SETTLE,
    LOAD,
    GO_LOW,
    GO_HIGH,
    WAIT_LOW,
    WAIT_HIGH,
    CHECK,
    COMPLETE,
    FAIL
  } seq_state_e;

endpackage

// File: rtl/config_rom.sv
// Combinational table of {slave addr, sub addr, data} words; unused indices read as zero.
module config_rom
  import i2c_config_pkg::*;
(
  input  logic [3:0]            idx,
  output logic [CFG_WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    case (idx)
      4'd0:    word = 24'h34_1E_00;
      4'd1:    word = 24'h34_00_17;
      4'd2:    word = 24'h34_02_17;
      4'd3:    word = 24'h34_04_79;
      4'd4:    word = 24'h34_06_79;
      4'd5:    word = 24'h34_08_12;
      4'd6:    word = 24'h34_0A_06;
      4'd7:    word = 24'h34_0C_00;
      4'd8:    word = 24'h34_0E_42;
      4'd9:    word = 24'h34_10_02;
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/i2c_config_seq.sv
// Walks the config table once after power-up settle, handing each word to an I2C
// serializer with per-word retry and handshake timeouts.
module i2c_config_seq
  import i2c_config_pkg::*;
#(
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  START,
  output logic [CFG_WORD_W-1:0] I2C_DATA,
  output logic                  GO,
  output logic                  W_R,
  input  logic                  END,
  input  logic                  ACK,
  output logic [3:0]            LUT_INDEX,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);

  if (NUM_REGS < 1 || NUM_REGS > 16 || MAX_RETRY < 1 || SETTLE_CYCLES < 1 || TIMEOUT < 1)
  begin : g_param_check
    $error("i2c_config_seq: NUM_REGS must be 1..16, other parameters >= 1");
  end

  localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  localparam logic [3:0]          LAST_IDX    = 4'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0]  LAST_TRY    = RETRY_W'(MAX_RETRY - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT - 1);

  seq_state_e            state_q, state_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                  go_cnt_q, go_cnt_d;
  logic [TMO_W-1:0]      low_cnt_q, low_cnt_d;
  logic [TMO_W-1:0]      high_cnt_q, high_cnt_d;
  logic [3:0]            index_q, index_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  ack_q, ack_d;
  logic [CFG_WORD_W-1:0] data_q, data_d;
  logic                  go_q, go_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [CFG_WORD_W-1:0] rom_word;

  config_rom u_rom (
    .idx  (index_q),
    .word (rom_word)
  );

  // Serializer handshake: GO is held high for the whole transfer; END must first
  // fall (transfer accepted) and then rise (transfer finished). ACK is only
  // meaningful in the cycle END is seen high, and 1 there means NACK.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    go_cnt_d     = 1'b0;
    low_cnt_d    = '0;
    high_cnt_d   = '0;
    index_d      = index_q;
    retry_d      = retry_q;
    ack_d        = ack_q;
    data_d       = data_q;

    case (state_q)
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = LOAD;
          index_d = '0;
          retry_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      LOAD: begin
        data_d  = rom_word;
        state_d = GO_LOW;
      end
      GO_LOW: begin
        if (go_cnt_q) state_d = GO_HIGH;
        else          go_cnt_d = 1'b1;
      end
      GO_HIGH: state_d = WAIT_LOW;
      WAIT_LOW: begin
        if (!END)                       state_d = WAIT_HIGH;
        else if (low_cnt_q == TMO_LAST) state_d = FAIL;
        else                            low_cnt_d = low_cnt_q + 1'b1;
      end
      WAIT_HIGH: begin
        if (END) begin
          ack_d   = ACK;
          state_d = CHECK;
        end else if (high_cnt_q == TMO_LAST) begin
          state_d = FAIL;
        end else begin
          high_cnt_d = high_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (!ack_q) begin
          if (index_q < LAST_IDX) begin
            index_d = index_q + 1'b1;
            retry_d = '0;
            state_d = LOAD;
          end else begin
            state_d = COMPLETE;
          end
        end else if (retry_q < LAST_TRY) begin
          retry_d = retry_q + 1'b1;
          state_d = LOAD;
        end else begin
          state_d = FAIL;
        end
      end
      COMPLETE, FAIL: begin
        if (START) begin
          index_d = '0;
          retry_d = '0;
          state_d = LOAD;
        end
      end
      default: state_d = SETTLE;
    endcase

    // Status flags are decoded from the next state so they register alongside it.
    go_d    = (state_d inside {GO_HIGH, WAIT_LOW, WAIT_HIGH});
    busy_d  = !(state_d inside {COMPLETE, FAIL});
    done_d  = (state_d == COMPLETE);
    error_d = (state_d == FAIL);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      go_cnt_q     <= 1'b0;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      index_q      <= '0;
      retry_q      <= '0;
      ack_q        <= 1'b0;
      data_q       <= '0;
      go_q         <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      go_cnt_q     <= go_cnt_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      index_q      <= index_d;
      retry_q      <= retry_d;
      ack_q        <= ack_d;
      data_q       <= data_d;
      go_q         <= go_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign I2C_DATA  = data_q;
  assign GO        = go_q;
  assign W_R       = 1'b0;
  assign LUT_INDEX = index_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Bench for i2c_config_seq: behavioural serializer, scenario table, and hand-written
// restart / mid-transfer reset sequences.
module tb_i2c_config_seq;

  localparam int W = 24;

  typedef struct {
    int         mode;
    int         exp_pulses;
    logic       exp_done;
    logic       exp_error;
    logic [3:0] exp_index;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic         END   = 1'b1;
  logic         ACK   = 1'b0;
  logic [W-1:0] I2C_DATA;
  logic         GO, W_R, BUSY, DONE, ERROR;
  logic [3:0]   LUT_INDEX;

  always #5 CLOCK = ~CLOCK;

  i2c_config_seq #(
    .NUM_REGS      (10),
    .MAX_RETRY     (3),
    .SETTLE_CYCLES (8),
    .TIMEOUT       (64)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .START     (START),
    .I2C_DATA  (I2C_DATA),
    .GO        (GO),
    .W_R       (W_R),
    .END       (END),
    .ACK       (ACK),
    .LUT_INDEX (LUT_INDEX),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERROR     (ERROR)
  );

  // ---------------- reference table ----------------
  function automatic logic [W-1:0] exp_word(input int i);
    case (i)
      0:       return 24'h341E00;
      1:       return 24'h340017;
      2:       return 24'h340217;
      3:       return 24'h340479;
      4:       return 24'h340679;
      5:       return 24'h340812;
      6:       return 24'h340A06;
      7:       return 24'h340C00;
      8:       return 24'h340E42;
      9:       return 24'h341002;
      default: return '0;
    endcase
  endfunction

  function automatic int find_idx(input logic [W-1:0] w);
    for (int i = 0; i < 10; i++) if (exp_word(i) == w) return i;
    return -1;
  endfunction

  // ---------------- serializer model ----------------
  // mode 0: always ACK; 1: NACK first attempt of index 3; 2: NACK every attempt
  // of index 5; 3: END never drops.
  int           mode = 0;
  int           attempts[16];
  logic [W-1:0] got_q[$];
  bit           go_prev;
  int           hold;
  int           cur;
  logic         nack;

  always begin
    @(posedge CLOCK);
    #1;
    if (!RESET) begin
      END     = 1'b1;
      ACK     = 1'b0;
      hold    = 0;
      go_prev = 1'b0;
      got_q.delete();
      for (int i = 0; i < 16; i++) attempts[i] = 0;
    end else begin
      if (GO && !go_prev) begin
        got_q.push_back(I2C_DATA);
        cur  = find_idx(I2C_DATA);
        nack = 1'b0;
        if (cur >= 0) begin
          nack = (mode == 1 && cur == 3 && attempts[cur] == 0) || (mode == 2 && cur == 5);
          attempts[cur]++;
        end
        if (mode != 3) begin
          END  = 1'b0;
          hold = 4;
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          END = 1'b1;
          ACK = nack;
        end
      end
      go_prev = GO;
    end
  end

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic build_exp(input int m);
    exp_q.delete();
    case (m)
      0: for (int i = 0; i < 10; i++) exp_q.push_back(exp_word(i));
      1: begin
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(i));
        exp_q.push_back(exp_word(3));
        for (int i = 4; i < 10; i++) exp_q.push_back(exp_word(i));
      end
      2: begin
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_word(i));
        exp_q.push_back(exp_word(5));
        exp_q.push_back(exp_word(5));
      end
      default: exp_q.push_back(exp_word(0));
    endcase
  endtask

  task automatic compare_words(input string tag, input int base);
    check({tag, "_word_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        check($sformatf("%s_word%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_go"},    32'(GO),        32'd0);
    check({tag, "_data"},  32'(I2C_DATA),  32'd0);
    check({tag, "_wr"},    32'(W_R),       32'd0);
    check({tag, "_index"}, 32'(LUT_INDEX), 32'd0);
    check({tag, "_done"},  32'(DONE),      32'd0);
    check({tag, "_error"}, 32'(ERROR),     32'd0);
    check({tag, "_busy"},  32'(BUSY),      32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return GO;
      1:       return ERROR;
      default: return !BUSY;
    endcase
  endfunction

  // n = negedges waited until the probe is true, or -1 if the budget ran out.
  task automatic wait_for(input int sel, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge CLOCK);
      n++;
      if (probe(sel)) return;
    end
    n = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    vec_t tbl[4];
    int   n;
    int   base;
    bit   found;

    tbl[0] = '{mode: 0, exp_pulses: 10, exp_done: 1'b1, exp_error: 1'b0, exp_index: 4'd9};
    tbl[1] = '{mode: 1, exp_pulses: 11, exp_done: 1'b1, exp_error: 1'b0, exp_index: 4'd9};
    tbl[2] = '{mode: 2, exp_pulses: 8,  exp_done: 1'b0, exp_error: 1'b1, exp_index: 4'd5};
    tbl[3] = '{mode: 3, exp_pulses: 1,  exp_done: 1'b0, exp_error: 1'b1, exp_index: 4'd0};

    for (int t = 0; t < 4; t++) begin
      mode = tbl[t].mode;
      apply_reset();
      wait_for(0, 100, n);
      check($sformatf("v%0d_settle_latency", t), n, 11);
      if (tbl[t].mode == 3) begin
        wait_for(1, 200, n);
        check($sformatf("v%0d_timeout_latency", t), n, 65);
      end
      wait_for(2, 3000, n);
      check($sformatf("v%0d_idle_reached", t), 32'(n > 0), 32'd1);
      check($sformatf("v%0d_done", t),  32'(DONE),      32'(tbl[t].exp_done));
      check($sformatf("v%0d_error", t), 32'(ERROR),     32'(tbl[t].exp_error));
      check($sformatf("v%0d_index", t), 32'(LUT_INDEX), 32'(tbl[t].exp_index));
      check($sformatf("v%0d_go", t),    32'(GO),        32'd0);
      check($sformatf("v%0d_busy", t),  32'(BUSY),      32'd0);
      check($sformatf("v%0d_pulses", t), got_q.size(), tbl[t].exp_pulses);
      build_exp(tbl[t].mode);
      compare_words($sformatf("v%0d", t), 0);
    end

    // START in COMPLETE reruns from index 0 without SETTLE; START while busy is ignored.
    mode = 0;
    apply_reset();
    wait_for(0, 100, n);
    wait_for(2, 3000, n);
    check("restart_pre_done", 32'(DONE), 32'd1);
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    check("restart_done_cleared", 32'(DONE),      32'd0);
    check("restart_busy",         32'(BUSY),      32'd1);
    check("restart_error",        32'(ERROR),     32'd0);
    check("restart_index",        32'(LUT_INDEX), 32'd0);
    base = got_q.size();
    wait_for(0, 100, n);
    check("restart_go_latency", n, 3);
    repeat (10) @(negedge CLOCK);
    check("start_while_busy_busy", 32'(BUSY), 32'd1);
    START = 1'b1;
    repeat (6) @(negedge CLOCK);
    START = 1'b0;
    wait_for(2, 3000, n);
    check("restart_idle_reached", 32'(n > 0), 32'd1);
    check("restart_done",  32'(DONE),  32'd1);
    check("restart_error_end", 32'(ERROR), 32'd0);
    build_exp(0);
    compare_words("restart", base);

    // Reset while word 4 is in WAIT_HIGH.
    mode = 0;
    apply_reset();
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge CLOCK);
      if (LUT_INDEX == 4'd4 && GO && !END) found = 1'b1;
    end
    check("midreset_reached", 32'(found), 32'd1);
    repeat (2) @(negedge CLOCK);
    check("midreset_go_before", 32'(GO), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    wait_for(0, 100, n);
    check("midreset_settle_latency", n, 11);
    wait_for(2, 3000, n);
    check("midreset_idle_reached", 32'(n > 0), 32'd1);
    check("midreset_done",  32'(DONE),  32'd1);
    check("midreset_error", 32'(ERROR), 32'd0);
    build_exp(0);
    compare_words("midreset", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_config_seq.md
I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

Interface
REQ-001 The block SHALL expose these parameters:
- NUM_REGS, 10, number of 24-bit configuration words sent per run.
- MAX_RETRY, 3, transfer attempts per word before failure.
- SETTLE_CYCLES, 1024, power-up wait before the first transfer.
- TIMEOUT, 64, maximum cycles to wait for each END edge.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- CLOCK  in  1  single clock, shared with the I2C serializer.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  level-sampled request to rerun the full table from index 0.
- I2C_DATA  out  24  {slave addr, sub addr, data} to the serializer.
- GO  out  1  serializer transfer request.
- W_R  out  1  fixed 0 (write).
- END  in  1  serializer done; 0 while a transfer is active.
- ACK  in  1  serializer NACK flag; 1 means not acknowledged.
- LUT_INDEX  out  4  index of the current word.
- BUSY  out  1  sequence in progress.
- DONE  out  1  all words acknowledged.
- ERROR  out  1  retry budget exhausted or handshake timeout.

Function
REQ-003 States SHALL be SETTLE, LOAD, GO_LOW, GO_HIGH, WAIT_LOW, WAIT_HIGH, CHECK, COMPLETE and FAIL.
REQ-004 SETTLE SHALL count SETTLE_CYCLES cycles, then go to LOAD with index=0 and retry=0.
REQ-005 LOAD SHALL register config_rom(index) onto I2C_DATA, then go to GO_LOW.
REQ-006 GO_LOW SHALL hold GO=0 for exactly 2 cycles, then go to GO_HIGH, which asserts GO=1.
- This guarantees the serializer counter restarts.
REQ-007 GO SHALL stay 1 from GO_HIGH through WAIT_LOW and WAIT_HIGH, and SHALL drop to 0 in CHECK.
REQ-008 WAIT_LOW SHALL wait for END=0; WAIT_HIGH SHALL then wait for END=1.
- A stale END=1 from a previous transfer is never taken as completion.
REQ-009 Each wait state SHALL have its own counter.
- Reaching TIMEOUT cycles SHALL go to FAIL.
- The counter SHALL clear on state entry.
REQ-010 CHECK SHALL sample ACK in the cycle END=1 is seen and branch:
- ACK=0 with index<NUM_REGS-1: index+1, retry=0, go to LOAD.
- ACK=0 with index=NUM_REGS-1: go to COMPLETE.
- ACK=1 with retry+1<MAX_RETRY: retry+1, same index, go to LOAD.
- ACK=1 with retry+1=MAX_RETRY: go to FAIL.
REQ-011 In COMPLETE, DONE SHALL be 1 and BUSY 0. In FAIL, ERROR SHALL be 1, BUSY 0, and LUT_INDEX SHALL freeze at the failing index.
REQ-012 START=1 in COMPLETE or FAIL SHALL, on the next cycle:
- clear DONE and ERROR;
- set index=0 and retry=0;
- enter LOAD, skipping SETTLE.
REQ-013 START SHALL be ignored while BUSY=1.
REQ-014 Counter widths:
- index: 4 bits; NUM_REGS ≤ 16 is enforced at elaboration.
- retry: clog2(MAX_RETRY+1) bits.
- Counters SHALL never wrap; each saturates at its terminal value.
REQ-015 BUSY SHALL be 1 in every state except COMPLETE and FAIL.
- All outputs SHALL be registered.

Reset
REQ-016 RESET=0 SHALL, asynchronously:
- enter SETTLE;
- set GO=0, I2C_DATA=0, W_R=0, LUT_INDEX=0, DONE=0, ERROR=0, BUSY=1;
- clear all counters.
REQ-017 Reset asserted mid-transfer SHALL drop GO within the same reset assertion.
- After release, the block SHALL restart from SETTLE.

Structure
REQ-018 Package i2c_config_pkg SHALL hold:
- the state encodings;
- default values for NUM_REGS, MAX_RETRY, SETTLE_CYCLES and TIMEOUT;
- the 24-bit word width constant.
REQ-019 Sub-module config_rom SHALL be a combinational index-to-24-bit table.
- It returns 24'h000000 for out-of-range indices.

Verification
REQ-020 Bench SHALL pair the block with a behavioural serializer model and SETTLE_CYCLES=8. It SHALL cover:
- Nominal: all ACK=0, NUM_REGS=10 → 10 GO pulses, I2C_DATA matches config_rom(0..9) in order, DONE=1, ERROR=0.
- NACK recovery: ACK=1 on the first attempt of index 3 only → 11 GO pulses, index 3 sent twice, DONE=1.
- Retry exhaustion: ACK=1 on every attempt of index 5 → 3 attempts, ERROR=1, LUT_INDEX=5, GO=0.
- Timeout: END held at 1 after GO rises → FAIL after 64 cycles in WAIT_LOW, ERROR=1.
- Restart: START=1 in COMPLETE → DONE clears next cycle, index 0 reloaded, no SETTLE wait. START=1 during BUSY → no effect.
- Reset mid-transfer: RESET=0 during WAIT_HIGH of index 4 → GO=0 immediately, all outputs at reset values, full run succeeds after release.
